fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the asynchronous FIFO's single write port among `NREQ` producers in the write-clock domain. It selects one requester per cycle and drives `winc`/`wdata` straight into the FIFO write side. It honours `wfull` and returns a per-requester valid/ready acknowledge. It also keeps a saturating count of accepted writes for debug and coverage.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; legal range 1..16.
- `DSIZE`, `` `DSIZE `` from `define.sv`: FIFO data width.
- `IDW`, `$clog2(NREQ)` (minimum 1): width of the requester ID.

Ports:
- `wclk`  in  1  write-domain clock; all state updates on posedge.
- `wrst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  requester i has a beat to write.
- `req_data`  in  NREQ*DSIZE  beat of requester i in bits [i*DSIZE +: DSIZE].
- `req_last`  in  NREQ  beat is the last of a packet; used only with `ARB_PKT_LOCK_EN`.
- `req_ready`  out  NREQ  one-hot; the beat of requester i is accepted this cycle.
- `wfull`  in  1  FIFO full, write domain.
- `winc`  out  1  FIFO write enable.
- `wdata`  out  DSIZE  FIFO write data.
- `grant_id`  out  IDW  ID of the most recently accepted requester, registered.
- `busy`  out  1  any `req_valid` is set, or a packet lock is held.
- `wr_count`  out  16  accepted-write counter; saturates at 0xFFFF.

## Operation
- Registered state:
  - `rr_ptr`: highest-priority requester for the next arbitration.
  - `lock_state`: OPEN or LOCKED.
  - `owner`: holder of the packet lock.
  - `grant_id`, `wr_count`.
- Selection (combinational):
  - `sel` is the first requester with `req_valid` set, scanning `rr_ptr`, `rr_ptr+1`, … mod NREQ.
  - In LOCKED, only `owner` is eligible.
- Accept condition:
  - `accept = eligible valid & ~wfull & ~wrst`.
  - On accept: `winc = 1`, `wdata = req_data[sel]`, `req_ready[sel] = 1`.
  - Otherwise `winc = 0`, `req_ready = 0`, and `wdata = 0`.
- On accept, at posedge:
  - `grant_id <= sel`.
  - `wr_count <= wr_count + 1`, unless already 0xFFFF.
  - Without lock: `rr_ptr <= (sel+1) mod NREQ`.
- Handshake rule for requesters: once `req_valid` is asserted, `req_valid` and `req_data` hold until `req_ready` is seen. The arbiter does not re-check this.
- `wfull` high:
  - No accept.
  - `rr_ptr`, lock state and `owner` are unchanged.
  - Requesters stall.
- Wrap-around: `rr_ptr` advances from NREQ-1 to 0.
- `NREQ = 1`: `rr_ptr` stays 0; the block degenerates to a pass-through gated by `wfull`.

## Timing
- Acceptance has zero latency: `req_valid` in cycle t with `wfull` low gives `winc`/`req_ready` in cycle t. The FIFO captures the data at the end of cycle t.
- Throughput is one write per cycle while `wfull` stays low.
- `wfull` is sampled combinationally in the same cycle. The arbiter never issues `winc` in a cycle where `wfull` is high.
- Reset:
  - While `wrst` is high: `winc = 0`, `req_ready = 0`, `wdata = 0`.
  - Next cycle: `rr_ptr = 0`, OPEN, `owner = 0`, `grant_id = 0`, `wr_count = 0`, `busy` follows its inputs.
- Reset during a packet releases the lock immediately. A partial packet already written stays in the FIFO.

## Configuration
- `ARB_PKT_LOCK_EN` defined: packet lock is enabled.
  - An accepted beat with `req_last[sel] = 0` sets LOCKED, `owner <= sel`. `rr_ptr` is not updated.
  - In LOCKED, only `owner` can be accepted.
  - If the owner deasserts `req_valid`, a bubble results (`winc = 0`) and other requesters stay blocked.
  - An accepted beat with `req_last[owner] = 1` returns to OPEN and sets `rr_ptr <= (owner+1) mod NREQ`.
  - A single-beat packet (`last = 1` on the first beat) never enters LOCKED.
- `ARB_PKT_LOCK_EN` not defined:
  - `req_last` is ignored.
  - `lock_state` is tied to OPEN.
  - Every beat re-arbitrates.

## Test plan
- Reset, then single-requester streaming: `wrst` = 1 for 2 cycles, then requester 2 only sends 0x10..0x14 with `wfull` = 0.
  - Expect 5 consecutive `winc` with `wdata` 0x10..0x14.
  - Expect `grant_id` = 2 and `wr_count` = 5.
- Fairness, lock disabled: all 4 requesters valid continuously.
  - Expect grant order 0,1,2,3,0,1,… with exactly one `req_ready` bit per cycle.
- Full back-pressure: all requesters valid, `wfull` high for 3 cycles starting at the cycle after requester 1 is accepted.
  - Expect `winc` = 0 and `req_ready` = 0 for those 3 cycles.
  - Next accept is requester 2.
- Packet lock, `ARB_PKT_LOCK_EN`: requester 0 sends a 3-beat packet while requester 1 is valid.
  - Requester 0 drops `valid` for 1 cycle mid-packet: expect a 1-cycle bubble and no grant to requester 1.
  - After requester 0's `last` beat is accepted, the next cycle grants requester 1.
- Reset mid-packet, `ARB_PKT_LOCK_EN`: `wrst` pulses after beat 1 of 3.
  - Expect OPEN and `rr_ptr` = 0 after reset.
  - With requesters 1 and 3 valid, requester 1 is granted next.
- Saturation: preload by 65 540 accepted writes.
  - Expect `wr_count` = 0xFFFF, holding.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing the async FIFO write port among NREQ producers
// Optional packet lock is compiled in when ARB_PKT_LOCK_EN is defined.
`ifndef DSIZE
`define DSIZE 8
`endif

module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = `DSIZE,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy,
    output logic [15:0]           wr_count
);

    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_grant_id;
    logic [15:0]    r_wr_count;
    logic [IDW-1:0] w_sel;
    logic [IDW-1:0] w_next_ptr;
    logic [IDW-1:0] w_owner;
    logic [IDW:0]   w_idx;
    logic           w_locked;
    logic           w_found;
    logic           w_accept;

`ifdef ARB_PKT_LOCK_EN
    typedef enum logic {OPEN, LOCKED} lock_t;
    lock_t          r_lock_state;
    logic [IDW-1:0] r_owner;

    assign w_locked = (r_lock_state == LOCKED);
    assign w_owner  = r_owner;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_lock_state <= OPEN;
            r_owner      <= '0;
        end else if (w_accept) begin
            if (req_last[w_sel]) begin
                r_lock_state <= OPEN;
            end else begin
                r_lock_state <= LOCKED;
                r_owner      <= w_sel;
            end
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = ^req_last;
    assign w_locked      = 1'b0;
    assign w_owner       = '0;
`endif

    // Scan downward so the requester closest to r_rr_ptr is the last (winning) assignment.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        if (w_locked) begin
            w_sel   = w_owner;
            w_found = req_valid[w_owner];
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
                if (w_idx >= (IDW+1)'(NREQ)) begin
                    w_idx = w_idx - (IDW+1)'(NREQ);
                end
                if (req_valid[w_idx[IDW-1:0]]) begin
                    w_sel   = w_idx[IDW-1:0];
                    w_found = 1'b1;
                end
            end
        end
    end

    assign w_accept   = w_found & ~wfull & ~wrst;
    assign w_next_ptr = (w_sel == IDW'(NREQ - 1)) ? '0 : w_sel + IDW'(1);

    always_comb begin
        wdata     = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_accept && (w_sel == IDW'(i))) begin
                wdata        = req_data[i*DSIZE +: DSIZE];
                req_ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_wr_count <= '0;
        end else if (w_accept) begin
            r_grant_id <= w_sel;
            if (r_wr_count != 16'hFFFF) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
`ifdef ARB_PKT_LOCK_EN
            if (req_last[w_sel]) begin
                r_rr_ptr <= w_next_ptr;
            end
`else
            r_rr_ptr <= w_next_ptr;
`endif
        end
    end

    assign winc     = w_accept;
    assign grant_id = r_grant_id;
    assign wr_count = r_wr_count;
    assign busy     = (|req_valid) | w_locked;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter (vectors, hand sequences, random vs model)
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int IDW   = 2;

    logic                  wclk = 1'b0;
    logic                  wrst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*DSIZE-1:0] req_data = '0;
    logic [NREQ-1:0]       req_last = '1;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull = 1'b0;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [IDW-1:0]        grant_id;
    logic                  busy;
    logic [15:0]           wr_count;

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .IDW(IDW)) dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .winc(winc),
        .wdata(wdata), .grant_id(grant_id), .busy(busy), .wr_count(wr_count)
    );

    always #5 wclk = ~wclk;

    // Reference model: arbitration state kept as plain integers.
    int m_rr = 0, m_owner = 0, m_gid = 0, m_cnt = 0, m_cand = -1;
    bit m_lock = 0, m_acc = 0, do_check = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_eval();
        m_cand = -1;
        if (m_lock) begin
            if (req_valid[m_owner]) m_cand = m_owner;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_cand < 0 && req_valid[(m_rr + k) % NREQ]) m_cand = (m_rr + k) % NREQ;
            end
        end
        m_acc = (m_cand >= 0) && !wfull && !wrst;
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                         input logic f, input logic r);
        logic [7:0] exp_d;
        req_valid = v; req_data = d; req_last = l; wfull = f; wrst = r;
        #4;
        model_eval();
        if (do_check) begin
            exp_d = 8'h00;
            if (m_acc) exp_d = req_data[m_cand*8 +: 8];
            chk("m_winc", winc, m_acc);
            chk("m_req_ready", req_ready, m_acc ? (32'd1 << m_cand) : 32'd0);
            chk("m_wdata", wdata, exp_d);
            chk("m_grant_id", grant_id, m_gid);
            chk("m_busy", busy, (|req_valid) || m_lock);
            chk("m_wr_count", wr_count, m_cnt);
        end
    endtask

    task automatic tick();
        if (wrst) begin
            m_rr = 0; m_owner = 0; m_gid = 0; m_cnt = 0; m_lock = 0;
        end else if (m_acc) begin
            m_gid = m_cand;
            if (m_cnt < 16'hFFFF) m_cnt++;
`ifdef ARB_PKT_LOCK_EN
            if (!req_last[m_cand]) begin
                m_lock = 1; m_owner = m_cand;
            end else begin
                m_lock = 0; m_rr = (m_cand + 1) % NREQ;
            end
`else
            m_rr = (m_cand + 1) % NREQ;
`endif
        end
        @(posedge wclk);
        #1;
    endtask

    function automatic int onehot_idx(input logic [3:0] oh);
        int idx = 0;
        for (int i = 0; i < NREQ; i++) if (oh[i]) idx = i;
        return idx;
    endfunction

    typedef struct {
        logic [3:0] v;
        logic       f;
        logic [3:0] l;
        logic [3:0] rdy;
        logic [1:0] gid;
    } vec_t;

    vec_t tbl[22];
    int   ntbl;

    task automatic run_vec(input vec_t t, input string tag);
        drive(t.v, 32'h43424140, t.l, t.f, 1'b0);
        chk({tag, "_ready"}, req_ready, t.rdy);
        chk({tag, "_winc"}, winc, |t.rdy);
        chk({tag, "_wdata"}, wdata, (|t.rdy) ? 8'h40 + onehot_idx(t.rdy) : 8'h00);
        chk({tag, "_gid"}, grant_id, t.gid);
        tick();
    endtask

    logic       pend [NREQ];
    logic [7:0] pdat [NREQ];
    logic       plst [NREQ];

    initial begin
        logic [3:0]  v, l;
        logic [31:0] d;

        // Reset held two cycles with every requester valid: outputs stay gated.
        @(posedge wclk); #1;
        for (int c = 0; c < 2; c++) begin
            drive(4'hF, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1);
            chk("rst_winc", winc, 0);
            chk("rst_ready", req_ready, 0);
            chk("rst_wdata", wdata, 0);
            tick();
        end
        drive(4'h0, 32'h0, 4'hF, 1'b0, 1'b0);
        chk("post_rst_gid", grant_id, 0);
        chk("post_rst_count", wr_count, 0);
        tick();

        // Requester 2 streams 0x10..0x14.
        for (int j = 0; j < 5; j++) begin
            drive(4'b0100, {8'h00, 8'(8'h10 + j), 16'h0000}, 4'hF, 1'b0, 1'b0);
            chk("stream_winc", winc, 1);
            chk("stream_wdata", wdata, 8'h10 + j);
            tick();
        end
        drive(4'h0, 32'h0, 4'hF, 1'b0, 1'b0);
        chk("stream_gid", grant_id, 2);
        chk("stream_count", wr_count, 5);
        tick();

        // Vector table: fairness, full back-pressure, wrap and sparse requests.
        drive(4'h0, 32'h0, 4'hF, 1'b0, 1'b1); tick();
        tbl[0]  = '{4'hF, 1'b0, 4'hF, 4'h1, 2'd0};
        tbl[1]  = '{4'hF, 1'b0, 4'hF, 4'h2, 2'd0};
        tbl[2]  = '{4'hF, 1'b0, 4'hF, 4'h4, 2'd1};
        tbl[3]  = '{4'hF, 1'b0, 4'hF, 4'h8, 2'd2};
        tbl[4]  = '{4'hF, 1'b0, 4'hF, 4'h1, 2'd3};
        tbl[5]  = '{4'hF, 1'b0, 4'hF, 4'h2, 2'd0};
        tbl[6]  = '{4'hF, 1'b1, 4'hF, 4'h0, 2'd1};
        tbl[7]  = '{4'hF, 1'b1, 4'hF, 4'h0, 2'd1};
        tbl[8]  = '{4'hF, 1'b1, 4'hF, 4'h0, 2'd1};
        tbl[9]  = '{4'hF, 1'b0, 4'hF, 4'h4, 2'd1};
        tbl[10] = '{4'h1, 1'b0, 4'hF, 4'h1, 2'd2};
        tbl[11] = '{4'h8, 1'b0, 4'hF, 4'h8, 2'd0};
        tbl[12] = '{4'h0, 1'b0, 4'hF, 4'h0, 2'd3};
        tbl[13] = '{4'hA, 1'b0, 4'hF, 4'h2, 2'd3};
        tbl[14] = '{4'hA, 1'b0, 4'hF, 4'h8, 2'd1};
        ntbl = 15;
        for (int i = 0; i < ntbl; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

`ifdef ARB_PKT_LOCK_EN
        // 3-beat packet from requester 0 with a mid-packet gap; requester 1 must wait.
        drive(4'h0, 32'h0, 4'hF, 1'b0, 1'b1); tick();
        tbl[15] = '{4'b0011, 1'b0, 4'b1110, 4'h1, 2'd0};
        tbl[16] = '{4'b0010, 1'b0, 4'b1110, 4'h0, 2'd0};
        tbl[17] = '{4'b0011, 1'b0, 4'b1110, 4'h1, 2'd0};
        tbl[18] = '{4'b0011, 1'b0, 4'b1111, 4'h1, 2'd0};
        tbl[19] = '{4'b0010, 1'b0, 4'b1111, 4'h2, 2'd0};
        for (int i = 15; i < 20; i++) run_vec(tbl[i], $sformatf("lock%0d", i));

        // Reset after beat 1 of a packet releases the lock and restarts at requester 0.
        drive(4'h0, 32'h0, 4'hF, 1'b0, 1'b1); tick();
        tbl[20] = '{4'b0001, 1'b0, 4'b1110, 4'h1, 2'd0};
        run_vec(tbl[20], "rstpkt_beat1");
        drive(4'b1010, 32'h43424140, 4'hF, 1'b0, 1'b1);
        chk("rstpkt_winc", winc, 0);
        chk("rstpkt_ready", req_ready, 0);
        tick();
        drive(4'h0, 32'h0, 4'hF, 1'b0, 1'b0);
        chk("rstpkt_busy", busy, 0);
        tick();
        tbl[21] = '{4'b1010, 1'b0, 4'hF, 4'h2, 2'd0};
        run_vec(tbl[21], "rstpkt_next");
`endif

        // Randomized traffic against the model; requesters obey the hold-until-ready rule.
        for (int i = 0; i < NREQ; i++) begin pend[i] = 0; pdat[i] = 0; plst[i] = 1; end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1;
                    pdat[i] = 8'($urandom);
                    plst[i] = ($urandom_range(0, 2) != 0);
                end
                v[i] = pend[i];
                l[i] = plst[i];
                d[i*8 +: 8] = pdat[i];
            end
            drive(v, d, l, ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
            if (m_acc) pend[m_cand] = 0;
            tick();
        end

        // Saturation: more than 65535 accepted writes.
        drive(4'h0, 32'h0, 4'hF, 1'b0, 1'b1); tick();
        do_check = 0;
        for (int c = 0; c < 65540; c++) begin
            drive(4'hF, 32'h43424140, 4'hF, 1'b0, 1'b0);
            tick();
        end
        do_check = 1;
        for (int c = 0; c < 3; c++) begin
            drive(4'hF, 32'h43424140, 4'hF, 1'b0, 1'b0);
            chk("sat_count", wr_count, 16'hFFFF);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
